// File: rtl/vga_timing_lookahead_pkg.sv
// Shared VGA timing constants, derived sizes and raster position type.
package vga_timing_lookahead_pkg;

  localparam int DEF_H_VISIBLE_AREA  = 640;
  localparam int DEF_H_FRONT_PORCH   = 16;
  localparam int DEF_H_SYNC_PULSE    = 96;
  localparam int DEF_H_BACK_PORCH    = 48;
  localparam int DEF_V_VISIBLE_AREA  = 480;
  localparam int DEF_V_FRONT_PORCH   = 10;
  localparam int DEF_V_SYNC_PULSE    = 2;
  localparam int DEF_V_BACK_PORCH    = 33;
  localparam int DEF_PIPELINE_STAGES = 2;
  localparam int DEF_FRAME_CNT_W     = 16;

  localparam int H_WHOLE_LINE = DEF_H_VISIBLE_AREA + DEF_H_FRONT_PORCH
                              + DEF_H_SYNC_PULSE + DEF_H_BACK_PORCH;
  localparam int V_WHOLE_LINE = DEF_V_VISIBLE_AREA + DEF_V_FRONT_PORCH
                              + DEF_V_SYNC_PULSE + DEF_V_BACK_PORCH;
  localparam int H_AW = $clog2(H_WHOLE_LINE);
  localparam int V_AW = $clog2(V_WHOLE_LINE);

  typedef struct packed {
    logic [H_AW-1:0] x;
    logic [V_AW-1:0] y;
  } vga_pos_t;

  // Half-open window test [lo, hi) used by all the raster decodes.
  function automatic logic in_window(input int v, input int lo, input int hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_lookahead_raster_counter.sv
// x/y raster counter pair; exposes next-state so callers can register
// decodes that line up with the position registers.
module vga_raster_counter #(
  parameter int H_WHOLE = 800,
  parameter int V_WHOLE = 525,
  parameter int RESET_X = 0,
  localparam int XW = $clog2(H_WHOLE),
  localparam int YW = $clog2(V_WHOLE)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [XW-1:0] x_nxt,
  output logic [YW-1:0] y_nxt,
  output logic          wrap
);

  localparam logic [XW-1:0] X_LAST = XW'(H_WHOLE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_WHOLE - 1);
  localparam logic [XW-1:0] X_RST  = XW'(RESET_X);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  logic x_end;
  assign x_end = (x == X_LAST);
  assign wrap  = en && x_end && (y == Y_LAST);

  // Next position: x steps and wraps, carry into y on end of line
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (en) begin
      if (x_end) begin
        x_nxt = '0;
        y_nxt = (y == Y_LAST) ? '0 : y + Y_ONE;
      end else begin
        x_nxt = x + X_ONE;
      end
    end
  end

  // Position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= X_RST;
      y <= '0;
    end else begin
      x <= x_nxt;
      y <= y_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_lookahead.sv
// VGA raster/timing generator with a lookahead raster running
// PIPELINE_STAGES ticks ahead of the display position.
module vga_timing_lookahead
  import vga_timing_lookahead_pkg::*;
#(
  parameter int H_VISIBLE_AREA  = DEF_H_VISIBLE_AREA,
  parameter int H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
  parameter int H_SYNC_PULSE    = DEF_H_SYNC_PULSE,
  parameter int H_BACK_PORCH    = DEF_H_BACK_PORCH,
  parameter int V_VISIBLE_AREA  = DEF_V_VISIBLE_AREA,
  parameter int V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
  parameter int V_SYNC_PULSE    = DEF_V_SYNC_PULSE,
  parameter int V_BACK_PORCH    = DEF_V_BACK_PORCH,
  parameter int PIPELINE_STAGES = DEF_PIPELINE_STAGES,
  parameter bit HSYNC_ACTIVE    = 1'b0,
  parameter bit VSYNC_ACTIVE    = 1'b0,
  parameter int FRAME_CNT_W     = DEF_FRAME_CNT_W,
  localparam int H_WHOLE = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
  localparam int V_WHOLE = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
  localparam int HAW     = $clog2(H_WHOLE),
  localparam int VAW     = $clog2(V_WHOLE)
)(
  input  logic                   vga_pix_clk,
  input  logic                   rst_n,
  input  logic                   pix_en,
  output logic [HAW-1:0]         sx,
  output logic [VAW-1:0]         sy,
  output logic                   display_enabled,
  output logic                   H_SYNC,
  output logic                   V_SYNC,
  output logic                   line_stb,
  output logic                   frame_stb,
  output logic [HAW-1:0]         sx_aot,
  output logic [VAW-1:0]         sy_aot,
  output logic                   display_enabled_aot,
  output logic                   frame_stb_aot,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int HS_LO = H_VISIBLE_AREA + H_FRONT_PORCH;
  localparam int HS_HI = HS_LO + H_SYNC_PULSE;
  localparam int VS_LO = V_VISIBLE_AREA + V_FRONT_PORCH;
  localparam int VS_HI = VS_LO + V_SYNC_PULSE;
  localparam logic [FRAME_CNT_W-1:0] FC_ONE = FRAME_CNT_W'(1);

  // Lookahead reset position must lie on the first line
  if (PIPELINE_STAGES < 0 || PIPELINE_STAGES >= H_WHOLE) begin : g_bad_stages
    $error("PIPELINE_STAGES must be in [0, H_WHOLE_LINE)");
  end

  logic [HAW-1:0] sx_nxt, sx_aot_nxt;
  logic [VAW-1:0] sy_nxt, sy_aot_nxt;
  logic           disp_wrap, aot_wrap_unused;

  vga_raster_counter #(.H_WHOLE(H_WHOLE), .V_WHOLE(V_WHOLE), .RESET_X(0)) u_disp (
    .clk(vga_pix_clk), .rst_n(rst_n), .en(pix_en),
    .x(sx), .y(sy), .x_nxt(sx_nxt), .y_nxt(sy_nxt), .wrap(disp_wrap)
  );

  vga_raster_counter #(.H_WHOLE(H_WHOLE), .V_WHOLE(V_WHOLE), .RESET_X(PIPELINE_STAGES)) u_aot (
    .clk(vga_pix_clk), .rst_n(rst_n), .en(pix_en),
    .x(sx_aot), .y(sy_aot), .x_nxt(sx_aot_nxt), .y_nxt(sy_aot_nxt), .wrap(aot_wrap_unused)
  );

  // Flags decoded from next position so they are valid alongside sx/sy
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      display_enabled     <= in_window(0, 0, H_VISIBLE_AREA) && in_window(0, 0, V_VISIBLE_AREA);
      display_enabled_aot <= in_window(PIPELINE_STAGES, 0, H_VISIBLE_AREA)
                             && in_window(0, 0, V_VISIBLE_AREA);
      H_SYNC              <= ~HSYNC_ACTIVE;
      V_SYNC              <= ~VSYNC_ACTIVE;
    end else begin
      display_enabled     <= in_window(int'(sx_nxt), 0, H_VISIBLE_AREA)
                             && in_window(int'(sy_nxt), 0, V_VISIBLE_AREA);
      display_enabled_aot <= in_window(int'(sx_aot_nxt), 0, H_VISIBLE_AREA)
                             && in_window(int'(sy_aot_nxt), 0, V_VISIBLE_AREA);
      H_SYNC              <= in_window(int'(sx_nxt), HS_LO, HS_HI) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
      V_SYNC              <= in_window(int'(sy_nxt), VS_LO, VS_HI) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
    end
  end

  // Completed-frame count, bumped on the display raster wrapping to (0,0)
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n)         frame_cnt <= '0;
    else if (disp_wrap) frame_cnt <= frame_cnt + FC_ONE;
  end

  // Strobes are combinational; held low while in reset or between ticks
  assign line_stb      = rst_n && pix_en && (sx == '0);
  assign frame_stb     = line_stb && (sy == '0);
  assign frame_stb_aot = rst_n && pix_en && (sx_aot == '0) && (sy_aot == '0);

endmodule

// File: tb/tb_vga_timing_lookahead.sv
// Scoreboard bench: three instances (default 640x480 P=2, small raster with
// P=0 and active-high syncs, small raster with maximal lookahead) checked
// against a tick-count reference model.
module tb_vga_timing_lookahead;

  typedef struct packed {
    int hv, hf, hs, hb, vv, vf, vs, vb, p, ha, va, fw;
  } cfg_t;

  typedef struct packed {
    int sx, sy, de, hs, vs, ls, fs, sxa, sya, dea, fsa, fc;
  } out_t;

  typedef struct packed { out_t a, b, c; } trio_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  always #5 clk = ~clk;

  // instance A: defaults
  logic [9:0]  a_sx, a_sxa;  logic [9:0] a_sy, a_sya;
  logic a_de, a_hs, a_vs, a_ls, a_fs, a_dea, a_fsa;  logic [15:0] a_fc;
  // instance B: 30x13 raster, P=0, active-high syncs
  logic [4:0]  b_sx, b_sxa;  logic [3:0] b_sy, b_sya;
  logic b_de, b_hs, b_vs, b_ls, b_fs, b_dea, b_fsa;  logic [3:0] b_fc;
  // instance C: 30x13 raster, P=29, active-low syncs
  logic [4:0]  c_sx, c_sxa;  logic [3:0] c_sy, c_sya;
  logic c_de, c_hs, c_vs, c_ls, c_fs, c_dea, c_fsa;  logic [2:0] c_fc;

  vga_timing_lookahead dut_a (
    .vga_pix_clk(clk), .rst_n(rst_n), .pix_en(pix_en), .sx(a_sx), .sy(a_sy),
    .display_enabled(a_de), .H_SYNC(a_hs), .V_SYNC(a_vs), .line_stb(a_ls), .frame_stb(a_fs),
    .sx_aot(a_sxa), .sy_aot(a_sya), .display_enabled_aot(a_dea), .frame_stb_aot(a_fsa),
    .frame_cnt(a_fc));

  vga_timing_lookahead #(
    .H_VISIBLE_AREA(16), .H_FRONT_PORCH(4), .H_SYNC_PULSE(6), .H_BACK_PORCH(4),
    .V_VISIBLE_AREA(6), .V_FRONT_PORCH(2), .V_SYNC_PULSE(2), .V_BACK_PORCH(3),
    .PIPELINE_STAGES(0), .HSYNC_ACTIVE(1'b1), .VSYNC_ACTIVE(1'b1), .FRAME_CNT_W(4)
  ) dut_b (
    .vga_pix_clk(clk), .rst_n(rst_n), .pix_en(pix_en), .sx(b_sx), .sy(b_sy),
    .display_enabled(b_de), .H_SYNC(b_hs), .V_SYNC(b_vs), .line_stb(b_ls), .frame_stb(b_fs),
    .sx_aot(b_sxa), .sy_aot(b_sya), .display_enabled_aot(b_dea), .frame_stb_aot(b_fsa),
    .frame_cnt(b_fc));

  vga_timing_lookahead #(
    .H_VISIBLE_AREA(16), .H_FRONT_PORCH(4), .H_SYNC_PULSE(6), .H_BACK_PORCH(4),
    .V_VISIBLE_AREA(6), .V_FRONT_PORCH(2), .V_SYNC_PULSE(2), .V_BACK_PORCH(3),
    .PIPELINE_STAGES(29), .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0), .FRAME_CNT_W(3)
  ) dut_c (
    .vga_pix_clk(clk), .rst_n(rst_n), .pix_en(pix_en), .sx(c_sx), .sy(c_sy),
    .display_enabled(c_de), .H_SYNC(c_hs), .V_SYNC(c_vs), .line_stb(c_ls), .frame_stb(c_fs),
    .sx_aot(c_sxa), .sy_aot(c_sya), .display_enabled_aot(c_dea), .frame_stb_aot(c_fsa),
    .frame_cnt(c_fc));

  cfg_t  cfg_a, cfg_b, cfg_c;
  trio_t sbq[$];
  longint t = 0;      // pixel ticks since last reset
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;

  // Reference: everything follows from the tick count since reset.
  function automatic out_t model(cfg_t c, longint tk, bit en, bit rn);
    out_t   o;
    longint hw = c.hv + c.hf + c.hs + c.hb;
    longint vw = c.vv + c.vf + c.vs + c.vb;
    longint ta = tk + c.p;
    o.sx  = int'(tk % hw);
    o.sy  = int'((tk / hw) % vw);
    o.sxa = int'(ta % hw);
    o.sya = int'((ta / hw) % vw);
    o.de  = (o.sx < c.hv && o.sy < c.vv) ? 1 : 0;
    o.dea = (o.sxa < c.hv && o.sya < c.vv) ? 1 : 0;
    o.hs  = (o.sx >= c.hv + c.hf && o.sx < c.hv + c.hf + c.hs) ? c.ha : 1 - c.ha;
    o.vs  = (o.sy >= c.vv + c.vf && o.sy < c.vv + c.vf + c.vs) ? c.va : 1 - c.va;
    o.ls  = (rn && en && o.sx == 0) ? 1 : 0;
    o.fs  = (o.ls == 1 && o.sy == 0) ? 1 : 0;
    o.fsa = (rn && en && o.sxa == 0 && o.sya == 0) ? 1 : 0;
    o.fc  = int'((tk / (hw * vw)) % (64'd1 << c.fw));
    return o;
  endfunction

  task automatic cmp(string nm, string inst, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s.%s cycle %0d: got %0d expected %0d", inst, nm, cyc, act, exp);
    end
  endtask

  task automatic chk(string inst, out_t a, out_t e);
    cmp("sx", inst, a.sx, e.sx);               cmp("sy", inst, a.sy, e.sy);
    cmp("display_enabled", inst, a.de, e.de);  cmp("H_SYNC", inst, a.hs, e.hs);
    cmp("V_SYNC", inst, a.vs, e.vs);           cmp("line_stb", inst, a.ls, e.ls);
    cmp("frame_stb", inst, a.fs, e.fs);        cmp("sx_aot", inst, a.sxa, e.sxa);
    cmp("sy_aot", inst, a.sya, e.sya);         cmp("display_enabled_aot", inst, a.dea, e.dea);
    cmp("frame_stb_aot", inst, a.fsa, e.fsa);  cmp("frame_cnt", inst, a.fc, e.fc);
  endtask

  // One clock: drive inputs just after the edge, queue the expected outputs
  task automatic step(bit en, bit rn);
    trio_t x;
    @(posedge clk);
    #1;
    pix_en = en;
    rst_n  = rn;
    if (!rn) t = 0;
    x.a = model(cfg_a, t, en, rn);
    x.b = model(cfg_b, t, en, rn);
    x.c = model(cfg_c, t, en, rn);
    sbq.push_back(x);
    if (rn && en) t++;
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle
  initial begin
    trio_t e;
    out_t  a;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        cyc++;
        a = '{int'(a_sx), int'(a_sy), int'(a_de), int'(a_hs), int'(a_vs), int'(a_ls),
              int'(a_fs), int'(a_sxa), int'(a_sya), int'(a_dea), int'(a_fsa), int'(a_fc)};
        chk("A", a, e.a);
        a = '{int'(b_sx), int'(b_sy), int'(b_de), int'(b_hs), int'(b_vs), int'(b_ls),
              int'(b_fs), int'(b_sxa), int'(b_sya), int'(b_dea), int'(b_fsa), int'(b_fc)};
        chk("B", a, e.b);
        a = '{int'(c_sx), int'(c_sy), int'(c_de), int'(c_hs), int'(c_vs), int'(c_ls),
              int'(c_fs), int'(c_sxa), int'(c_sya), int'(c_dea), int'(c_fsa), int'(c_fc)};
        chk("C", a, e.c);
      end
    end
  end

  initial begin
    cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 0, 0, 16};
    cfg_b = '{16, 4, 6, 4, 6, 2, 2, 3, 0, 1, 1, 4};
    cfg_c = '{16, 4, 6, 4, 6, 2, 2, 3, 29, 0, 0, 3};

    // reset held, with and without pix_en
    repeat (2) step(1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    // full line plus 100 ticks with pix_en tied high
    repeat (900) step(1'b1, 1'b1);
    // freeze mid-line, then resume
    repeat (10) step(1'b0, 1'b1);
    repeat (900) step(1'b1, 1'b1);
    // random pixel enables
    repeat (4000) step(($urandom_range(0, 3) != 0), 1'b1);
    // mid-frame reset asserted between edges
    repeat (3) step(($urandom_range(0, 1) != 0), 1'b0);
    repeat (1200) step(1'b1, 1'b1);
    repeat (2500) step(($urandom_range(0, 4) != 0), 1'b1);

    @(negedge clk);
    #1;
    cmp("queue_drained", "tb", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
